// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pkg
// Purpose  : Shared widths, lane/access constants and read FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    localparam int c_ADDR_W   = 2;
    localparam int c_DATA_W   = 16;
    localparam int c_BYTE_W   = 8;
    localparam int c_NUM_REGS = 1 << c_ADDR_W;

    localparam logic c_LANE_LO  = 1'b0;
    localparam logic c_LANE_HI  = 1'b1;
    localparam logic c_ACC_BYTE = 1'b0;
    localparam logic c_ACC_WORD = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_bank_lane_merge.sv
`default_nettype none
// ============================================================================
// Module   : lane_merge
// Purpose  : Byte/word merge of write data into a register (MERGE=1) or
//            lane extraction with zero extension for reads (MERGE=0).
// Revision : 1.0 - initial release
// ============================================================================
module lane_merge
    import reg_bank_pkg::*;
#(
    parameter bit MERGE = 1'b1
) (
    input  logic [c_DATA_W-1:0] i_base,
    input  logic [c_DATA_W-1:0] i_data,
    input  logic                i_word,
    input  logic                i_high,
    output logic [c_DATA_W-1:0] o_data
);

    if (MERGE) begin : g_merge
        // Byte writes always source WR_DATA[7:0], whichever lane they target.
        always_comb begin
            o_data = i_base;
            if (i_word == c_ACC_WORD) begin
                o_data = i_data;
            end else begin
                case (i_high)
                    c_LANE_HI: o_data[c_DATA_W-1:c_BYTE_W] = i_data[c_BYTE_W-1:0];
                    c_LANE_LO: o_data[c_BYTE_W-1:0]        = i_data[c_BYTE_W-1:0];
                    default:   o_data                      = i_base;
                endcase
            end
        end
    end else begin : g_extract
        logic w_unused_base;
        assign w_unused_base = ^i_base;

        always_comb begin
            o_data = i_data;
            if (i_word == c_ACC_BYTE) begin
                case (i_high)
                    c_LANE_HI: o_data = {{c_BYTE_W{1'b0}}, i_data[c_DATA_W-1:c_BYTE_W]};
                    c_LANE_LO: o_data = {{c_BYTE_W{1'b0}}, i_data[c_BYTE_W-1:0]};
                    default:   o_data = i_data;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank
// Purpose  : Four 16-bit registers with captured selects, byte/word access
//            and a one-deep held read port with write-through bypass.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter logic [c_DATA_W-1:0] RST_VAL = 16'h0000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ADR_LD,
    input  logic                RA,
    input  logic                RB,
    input  logic                WA,
    input  logic                WB,
    input  logic                W_B_R,
    input  logic                H_L_R,
    input  logic                RD_REQ,
    input  logic                RD_ACK,
    output logic                RD_RDY,
    output logic                RD_VLD,
    output logic [c_DATA_W-1:0] RD_DATA,
    input  logic                WR_EN,
    input  logic [c_DATA_W-1:0] WR_DATA
);

    logic [c_DATA_W-1:0] r_regs [c_NUM_REGS];
    logic [c_ADDR_W-1:0] r_rd_idx;
    logic [c_ADDR_W-1:0] r_wr_idx;
    logic                r_word;
    logic                r_high;
    rd_state_t           r_state;
    logic [c_DATA_W-1:0] r_rd_data;

    logic [c_ADDR_W-1:0] w_rd_idx;
    logic [c_ADDR_W-1:0] w_wr_idx;
    logic                w_word;
    logic                w_high;
    logic [c_DATA_W-1:0] w_wr_merged;
    logic [c_DATA_W-1:0] w_rd_src;
    logic [c_DATA_W-1:0] w_rd_val;
    rd_state_t           w_next;
    logic                w_load;

    // Selects presented with ADR_LD take effect in the same cycle.
    assign w_rd_idx = ADR_LD ? {RA, RB} : r_rd_idx;
    assign w_wr_idx = ADR_LD ? {WA, WB} : r_wr_idx;
    assign w_word   = ADR_LD ? W_B_R    : r_word;
    assign w_high   = ADR_LD ? H_L_R    : r_high;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_word   <= 1'b0;
            r_high   <= 1'b0;
        end else if (ADR_LD) begin
            r_rd_idx <= {RA, RB};
            r_wr_idx <= {WA, WB};
            r_word   <= W_B_R;
            r_high   <= H_L_R;
        end
    end

    lane_merge #(.MERGE(1'b1)) u_wr_merge (
        .i_base (r_regs[w_wr_idx]),
        .i_data (WR_DATA),
        .i_word (w_word),
        .i_high (w_high),
        .o_data (w_wr_merged)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= RST_VAL;
            end
        end else if (WR_EN) begin
            r_regs[w_wr_idx] <= w_wr_merged;
        end
    end

    assign w_rd_src = (WR_EN && (w_wr_idx == w_rd_idx)) ? w_wr_merged : r_regs[w_rd_idx];

    lane_merge #(.MERGE(1'b0)) u_rd_extract (
        .i_base (r_regs[w_rd_idx]),
        .i_data (w_rd_src),
        .i_word (w_word),
        .i_high (w_high),
        .o_data (w_rd_val)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        RD_RDY = 1'b0;
        RD_VLD = 1'b0;
        case (r_state)
            ST_IDLE: begin
                RD_RDY = 1'b1;
                if (RD_REQ) begin
                    w_next = ST_HOLD;
                    w_load = 1'b1;
                end
            end
            ST_HOLD: begin
                RD_VLD = 1'b1;
                if (RD_ACK) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_data <= '0;
        end else if (w_load) begin
            r_rd_data <= w_rd_val;
        end
    end

    assign RD_DATA = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank
// Purpose  : Self-checking bench for reg_bank against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank;

    localparam logic [15:0] TB_RST_VAL = 16'hC3A5;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ADR_LD, RA, RB, WA, WB, W_B_R, H_L_R;
    logic        RD_REQ, RD_ACK, WR_EN;
    logic        RD_RDY, RD_VLD;
    logic [15:0] RD_DATA, WR_DATA;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [15:0] m_reg [4];
    logic [1:0]  m_ri, m_wi;
    logic        m_wbr, m_hlr, m_hold;
    logic [15:0] m_data;

    reg_bank #(.RST_VAL(TB_RST_VAL)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .ADR_LD  (ADR_LD),
        .RA      (RA),
        .RB      (RB),
        .WA      (WA),
        .WB      (WB),
        .W_B_R   (W_B_R),
        .H_L_R   (H_L_R),
        .RD_REQ  (RD_REQ),
        .RD_ACK  (RD_ACK),
        .RD_RDY  (RD_RDY),
        .RD_VLD  (RD_VLD),
        .RD_DATA (RD_DATA),
        .WR_EN   (WR_EN),
        .WR_DATA (WR_DATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    task automatic clear_inputs();
        ADR_LD = 1'b0; RA = 1'b0; RB = 1'b0; WA = 1'b0; WB = 1'b0;
        W_B_R = 1'b0; H_L_R = 1'b0;
        RD_REQ = 1'b0; RD_ACK = 1'b0; WR_EN = 1'b0; WR_DATA = 16'h0000;
    endtask

    task automatic set_sel(input logic [1:0] ri, input logic [1:0] wi,
                           input logic wbr, input logic hlr);
        ADR_LD = 1'b1;
        {RA, RB} = ri;
        {WA, WB} = wi;
        W_B_R = wbr;
        H_L_R = hlr;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = TB_RST_VAL;
        m_ri = 2'd0; m_wi = 2'd0; m_wbr = 1'b0; m_hlr = 1'b0;
        m_hold = 1'b0; m_data = 16'h0000;
    endtask

    // Applies the current inputs to the model as one rising edge would.
    task automatic model_edge();
        logic [15:0] v;
        if (!RST_N) return;
        if (ADR_LD) begin
            m_ri = {RA, RB}; m_wi = {WA, WB}; m_wbr = W_B_R; m_hlr = H_L_R;
        end
        if (WR_EN) begin
            v = m_reg[m_wi];
            if (m_wbr)      v = WR_DATA;
            else if (m_hlr) v = {WR_DATA[7:0], v[7:0]};
            else            v = {v[15:8], WR_DATA[7:0]};
            m_reg[m_wi] = v;
        end
        if (!m_hold) begin
            if (RD_REQ) begin
                v = m_reg[m_ri];
                if (m_wbr)      m_data = v;
                else if (m_hlr) m_data = v / 256;
                else            m_data = v % 256;
                m_hold = 1'b1;
            end
        end else if (RD_ACK) begin
            m_hold = 1'b0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    // Issues a read with the selects already presented, samples it, then acks.
    task automatic do_read(output logic vld, output logic [15:0] data);
        RD_REQ = 1'b1;
        step();
        ADR_LD = 1'b0; RD_REQ = 1'b0; WR_EN = 1'b0;
        vld  = RD_VLD;
        data = RD_DATA;
        RD_ACK = 1'b1;
        step();
        RD_ACK = 1'b0;
    endtask

    task automatic test_reset();
        logic        vld;
        logic [15:0] d;
        clear_inputs();
        RST_N = 1'b0;
        model_reset();
        #2;
        n_checks++; if (RD_VLD !== 1'b0) begin n_errors++; $display("FAIL reset_vld: got %b expected 0", RD_VLD); end
        n_checks++; if (RD_RDY !== 1'b1) begin n_errors++; $display("FAIL reset_rdy: got %b expected 1", RD_RDY); end
        n_checks++; if (RD_DATA !== 16'h0000) begin n_errors++; $display("FAIL reset_data: got %h expected 0000", RD_DATA); end
        step();
        step();
        RST_N = 1'b1;
        set_sel(2'd1, 2'd0, 1'b1, 1'b0);
        do_read(vld, d);
        n_checks++; if (vld !== 1'b1) begin n_errors++; $display("FAIL first_edge_vld: got %b expected 1", vld); end
        n_checks++; if (d !== TB_RST_VAL) begin n_errors++; $display("FAIL reset_val_r1: got %h expected %h", d, TB_RST_VAL); end
    endtask

    task automatic test_word_write_read();
        clear_inputs();
        set_sel(2'd2, 2'd2, 1'b1, 1'b0);
        WR_EN = 1'b1; WR_DATA = 16'hBEEF;
        step();
        clear_inputs();
        RD_REQ = 1'b1;
        n_checks++; if (RD_VLD !== 1'b0) begin n_errors++; $display("FAIL word_pre_vld: got %b expected 0", RD_VLD); end
        step();
        RD_REQ = 1'b0;
        n_checks++; if (RD_VLD !== 1'b1) begin n_errors++; $display("FAIL word_latency_vld: got %b expected 1", RD_VLD); end
        n_checks++; if (RD_DATA !== 16'hBEEF) begin n_errors++; $display("FAIL word_data: got %h expected BEEF", RD_DATA); end
        RD_ACK = 1'b1;
        step();
        RD_ACK = 1'b0;
        n_checks++; if (RD_RDY !== 1'b1 || RD_VLD !== 1'b0) begin n_errors++; $display("FAIL word_ack: got rdy=%b vld=%b expected rdy=1 vld=0", RD_RDY, RD_VLD); end
    endtask

    task automatic test_byte_lanes();
        logic        vld;
        logic [15:0] d;
        clear_inputs();
        set_sel(2'd1, 2'd1, 1'b1, 1'b0); WR_EN = 1'b1; WR_DATA = 16'h1234; step();
        set_sel(2'd1, 2'd1, 1'b0, 1'b1); WR_EN = 1'b1; WR_DATA = 16'h00AB; step();
        clear_inputs();
        set_sel(2'd1, 2'd1, 1'b1, 1'b0); do_read(vld, d);
        n_checks++; if (d !== 16'hAB34) begin n_errors++; $display("FAIL byte_hi_write: got %h expected AB34", d); end
        set_sel(2'd1, 2'd1, 1'b0, 1'b0); do_read(vld, d);
        n_checks++; if (d !== 16'h0034) begin n_errors++; $display("FAIL byte_lo_read: got %h expected 0034", d); end
        set_sel(2'd1, 2'd1, 1'b0, 1'b1); do_read(vld, d);
        n_checks++; if (d !== 16'h00AB) begin n_errors++; $display("FAIL byte_hi_read: got %h expected 00AB", d); end
        set_sel(2'd1, 2'd1, 1'b0, 1'b0); WR_EN = 1'b1; WR_DATA = 16'hFF5C; step();
        clear_inputs();
        set_sel(2'd1, 2'd1, 1'b1, 1'b0); do_read(vld, d);
        n_checks++; if (d !== 16'hAB5C) begin n_errors++; $display("FAIL byte_lo_write: got %h expected AB5C", d); end
    endtask

    task automatic test_hold_stall();
        logic        vld;
        logic [15:0] d;
        clear_inputs();
        set_sel(2'd2, 2'd2, 1'b1, 1'b0); WR_EN = 1'b1; WR_DATA = 16'h1111; step();
        clear_inputs();
        RD_REQ = 1'b1; step();
        n_checks++; if (RD_VLD !== 1'b1 || RD_DATA !== 16'h1111) begin n_errors++; $display("FAIL stall_start: got vld=%b data=%h expected vld=1 data=1111", RD_VLD, RD_DATA); end
        for (int i = 0; i < 5; i++) begin
            RD_REQ = 1'b1; RD_ACK = 1'b0; WR_EN = 1'b1; WR_DATA = 16'h2000 + 16'(i);
            step();
            n_checks++; if (RD_DATA !== 16'h1111) begin n_errors++; $display("FAIL stall_data[%0d]: got %h expected 1111", i, RD_DATA); end
            n_checks++; if (RD_RDY !== 1'b0 || RD_VLD !== 1'b1) begin n_errors++; $display("FAIL stall_flags[%0d]: got rdy=%b vld=%b expected rdy=0 vld=1", i, RD_RDY, RD_VLD); end
        end
        WR_EN = 1'b0; RD_REQ = 1'b1; RD_ACK = 1'b1; step();
        clear_inputs();
        n_checks++; if (RD_VLD !== 1'b0 || RD_RDY !== 1'b1) begin n_errors++; $display("FAIL ack_cycle_req_ignored: got vld=%b rdy=%b expected vld=0 rdy=1", RD_VLD, RD_RDY); end
        do_read(vld, d);
        n_checks++; if (d !== 16'h2004) begin n_errors++; $display("FAIL stall_writes_landed: got %h expected 2004", d); end
    endtask

    task automatic test_bypass();
        logic        vld;
        logic [15:0] d;
        clear_inputs();
        set_sel(2'd3, 2'd3, 1'b1, 1'b0); WR_EN = 1'b1; WR_DATA = 16'h5A5A;
        do_read(vld, d);
        n_checks++; if (vld !== 1'b1 || d !== 16'h5A5A) begin n_errors++; $display("FAIL bypass_word: got vld=%b data=%h expected vld=1 data=5A5A", vld, d); end
        set_sel(2'd3, 2'd3, 1'b0, 1'b1); WR_EN = 1'b1; WR_DATA = 16'h00C3;
        do_read(vld, d);
        n_checks++; if (d !== 16'h00C3) begin n_errors++; $display("FAIL bypass_byte_hi: got %h expected 00C3", d); end
        set_sel(2'd3, 2'd0, 1'b1, 1'b0); WR_EN = 1'b1; WR_DATA = 16'h7777;
        do_read(vld, d);
        n_checks++; if (d !== 16'hC35A) begin n_errors++; $display("FAIL no_bypass_other_reg: got %h expected C35A", d); end
    endtask

    task automatic test_reset_in_hold();
        logic        vld;
        logic [15:0] d;
        clear_inputs();
        set_sel(2'd0, 2'd0, 1'b1, 1'b0); WR_EN = 1'b1; WR_DATA = 16'hFFFF; step();
        clear_inputs();
        RD_REQ = 1'b1; step();
        RD_REQ = 1'b0;
        n_checks++; if (RD_VLD !== 1'b1 || RD_DATA !== 16'hFFFF) begin n_errors++; $display("FAIL hold_before_reset: got vld=%b data=%h expected vld=1 data=FFFF", RD_VLD, RD_DATA); end
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        n_checks++; if (RD_VLD !== 1'b0 || RD_RDY !== 1'b1 || RD_DATA !== 16'h0000) begin n_errors++; $display("FAIL async_reset_in_hold: got vld=%b rdy=%b data=%h expected vld=0 rdy=1 data=0000", RD_VLD, RD_RDY, RD_DATA); end
        step();
        step();
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (RD_VLD !== 1'b0) begin n_errors++; $display("FAIL no_stale_vld[%0d]: got %b expected 0", i, RD_VLD); end
        end
        set_sel(2'd0, 2'd0, 1'b1, 1'b0);
        do_read(vld, d);
        n_checks++; if (d !== TB_RST_VAL) begin n_errors++; $display("FAIL r0_after_reset: got %h expected %h", d, TB_RST_VAL); end
    endtask

    task automatic test_random();
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            ADR_LD  = ($urandom_range(0, 3) == 0);
            RA      = 1'($urandom); RB = 1'($urandom);
            WA      = 1'($urandom); WB = 1'($urandom);
            W_B_R   = 1'($urandom); H_L_R = 1'($urandom);
            RD_REQ  = 1'($urandom);
            RD_ACK  = ($urandom_range(0, 2) == 0);
            WR_EN   = 1'($urandom);
            WR_DATA = 16'($urandom);
            step();
            n_checks++; if (RD_VLD !== m_hold) begin n_errors++; $display("FAIL rand_vld[%0d]: got %b expected %b", i, RD_VLD, m_hold); end
            n_checks++; if (RD_RDY !== !m_hold) begin n_errors++; $display("FAIL rand_rdy[%0d]: got %b expected %b", i, RD_RDY, !m_hold); end
            n_checks++; if (RD_DATA !== m_data) begin n_errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, RD_DATA, m_data); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_word_write_read();
        test_byte_lanes();
        test_hold_stall();
        test_bypass();
        test_reset_in_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter RST_VAL, default 16'h0000: reset value of every register.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 ADR_LD  input  1  strobe; capture RA, RB, WA, WB, W_B_R, H_L_R this cycle.
REQ-005 RA, RB  input  1 each  read register select, index {RA,RB}.
REQ-006 WA, WB  input  1 each  write register select, index {WA,WB}.
REQ-007 W_B_R  input  1  access width: 1 = word, 0 = byte.
REQ-008 H_L_R  input  1  byte lane for byte access: 1 = high [15:8], 0 = low [7:0].
REQ-009 RD_REQ  input  1  read request using the captured read select.
REQ-010 RD_ACK  input  1  consumer accepts RD_DATA.
REQ-011 RD_RDY  output  1  bank can accept RD_REQ.
REQ-012 RD_VLD  output  1  RD_DATA valid.
REQ-013 RD_DATA  output  16  read result.
REQ-014 WR_EN  input  1  write WR_DATA to the captured write select.
REQ-015 WR_DATA  input  16  write data; byte writes use WR_DATA[7:0] for either lane.

Function
REQ-016 Storage SHALL be four 16-bit registers R0..R3.
REQ-017 On ADR_LD the six select inputs SHALL be registered; RD_REQ/WR_EN in the same cycle SHALL use the newly presented values, not the previously captured ones.
REQ-018 The read FSM SHALL have states IDLE and HOLD; RD_RDY = (state==IDLE); RD_VLD = (state==HOLD).
REQ-019 IDLE with RD_REQ SHALL go to HOLD next cycle with RD_DATA loaded; latency exactly one cycle.
REQ-020 HOLD with RD_ACK SHALL return to IDLE; HOLD without RD_ACK SHALL hold RD_DATA stable.
REQ-021 RD_REQ while in HOLD SHALL be ignored, including in the RD_ACK cycle (no back-to-back reads; throughput one per two cycles).
REQ-022 Word read SHALL return the full register; byte read SHALL return the selected lane zero-extended to 16 bits.
REQ-023 WR_EN word write SHALL replace the full register; byte write SHALL replace only the selected lane, the other lane unchanged.
REQ-024 WR_EN SHALL be accepted every cycle regardless of FSM state.
REQ-025 RD_REQ and WR_EN to the same register in the same cycle SHALL return the post-write value (write-through bypass, byte merge applied).
REQ-026 A write to the register held in HOLD SHALL NOT change RD_DATA.
REQ-027 W_B_R and H_L_R SHALL apply to both read and write of the same captured access.

Reset
REQ-028 RST_N low SHALL immediately set R0..R3 to RST_VAL, captured selects to 0, state to IDLE, RD_VLD 0, RD_RDY 1, RD_DATA 16'h0000.
REQ-029 Reset mid-HOLD SHALL discard the pending read; no RD_VLD after release until a new RD_REQ.
REQ-030 First rising CLK after RST_N release SHALL act on inputs normally.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, register index width (2), data width (16) and lane select constants.
REQ-032 One sub-module, lane_merge, SHALL perform byte/word merge for writes and lane extraction for reads, instantiated once each.

Verification
REQ-033 Reset, ADR_LD {WA,WB}=2'b10, W_B_R=1, WR_EN, WR_DATA=16'hBEEF; then read select 2 word -> RD_DATA=16'hBEEF, RD_VLD one cycle after RD_REQ.
REQ-034 R1=16'h1234; byte write H_L_R=1, WR_DATA=16'h00AB -> R1=16'hAB34; byte read low -> 16'h0034, high -> 16'h00AB.
REQ-035 RD_REQ with RD_ACK held low 5 cycles plus concurrent write to same register -> RD_DATA constant, RD_RDY low, second RD_REQ ignored.
REQ-036 Same-cycle RD_REQ and word WR_EN to R3, WR_DATA=16'h5A5A -> RD_DATA=16'h5A5A.
REQ-037 RST_N asserted in HOLD with R0=16'hFFFF -> RD_VLD 0 immediately, R0 reads RST_VAL after release.
